// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux channel among four requesters.
// Grants are held for up to MAX_HOLD cycles while the owner keeps requesting, then rotate.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       S0,
    output logic       S1,
    output logic       ACTIVE
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_active;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] w_ptr_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_active_nxt;
    logic [2:0] w_arb;
    logic [1:0] w_next_start;

    // Returns {found, index} of the first request seen scanning from start upward, modulo 4.
    function automatic logic [2:0] arb(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_next_start = r_sel + 2'd1;

    // Next-state, hold counter, pointer and grant decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_arb       = 3'b000;
        case (r_state)
            ST_IDLE: begin
                w_arb = arb(REQ, r_ptr);
                if (w_arb[2]) begin
                    w_state_nxt = ST_GRANT;
                    w_cnt_nxt   = 4'd1;
                    w_gnt_nxt   = 4'b0001 << w_arb[1:0];
                    w_sel_nxt   = w_arb[1:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // r_sel always names the current owner while in GRANT.
                if (!REQ[r_sel] || (r_cnt == HOLD_LIM)) begin
                    w_ptr_nxt = w_next_start;
                    w_arb     = arb(REQ, w_next_start);
                    if (w_arb[2]) begin
                        w_cnt_nxt = 4'd1;
                        w_gnt_nxt = 4'b0001 << w_arb[1:0];
                        w_sel_nxt = w_arb[1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
        w_active_nxt = |w_gnt_nxt;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_ptr    <= 2'd0;
            r_gnt    <= 4'b0000;
            r_sel    <= 2'd0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_sel    <= w_sel_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign GNT    = r_gnt;
    assign S0     = r_sel[1];
    assign S1     = r_sel[0];
    assign ACTIVE = r_active;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux channel between four requesters.
- Drives the mux select pair S0/S1 (S0 = MSB: 00→X0, 01→X1, 10→X2, 11→X3) and a one-hot grant back to the requesters.
- A grant is held while the owner keeps requesting, up to a burst limit, then rotates.
- Sits between the requester logic and the mux4 datapath; the mux itself stays combinational.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the channel; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  4  request lines; bit i = requester i wants input Xi.
- GNT  output  4  one-hot grant, registered; all zero when idle.
- S0  output  1  mux select MSB, registered.
- S1  output  1  mux select LSB, registered.
- ACTIVE  output  1  high while any grant is asserted (equals |GNT).

Behaviour:
- Reset (async assert, sync release on next CLK edge):
  - GNT=0000, S0=0, S1=0, ACTIVE=0.
  - Internal: state=IDLE, hold counter CNT=0, round-robin pointer PTR=0.
- All outputs are registered. A grant appears one cycle after the edge that samples the request.
- Arbitration function ARB(mask, start): first set bit of REQ scanning start, start+1, … mod 4. Returns the index, or none.
- States:
  - IDLE:
    - REQ==0000 → stay IDLE, outputs unchanged (S0/S1 hold last value).
    - Otherwise k=ARB(REQ, PTR). Next cycle: GNT=one-hot(k), {S0,S1}=k, ACTIVE=1, CNT=1, state→GRANT.
  - GRANT (owner o):
    - Release condition: REQ[o]==0 OR CNT==MAX_HOLD.
    - No release → CNT increments; GNT, S0, S1 stable.
    - On release: PTR=(o+1) mod 4; k=ARB(REQ, (o+1) mod 4).
      - k exists → direct handoff, no idle gap. Next cycle GNT=one-hot(k), {S0,S1}=k, CNT=1, stay GRANT.
      - k==o is allowed only when o is the sole requester at hold expiry; o is regranted with a fresh CNT=1.
      - No k → GNT=0000, ACTIVE=0, CNT=0, state→IDLE; S0/S1 hold o.
- Selects change only on the same edge that GNT changes. GNT is never multi-hot, and never zero in GRANT state.
- REQ of non-owners has no effect until the release edge. A requester dropping REQ while not owner is simply skipped.
- MAX_HOLD=1: every grant lasts exactly one cycle and rotates each cycle among active requesters.
- Reset asserted mid-grant: GNT and ACTIVE go low immediately (asynchronously), PTR returns to 0.
- Fairness: with all four requesting continuously, each gets MAX_HOLD cycles in order 0,1,2,3,0…
- CNT width = 4 bits. It never exceeds MAX_HOLD.

Test Plan:
- Reset: RST_N low with REQ=1111 → GNT=0000, S0=S1=0, ACTIVE=0 throughout. Release → first edge samples, GNT=0001 one cycle later.
- Single requester: REQ=0100 held 3 cycles then dropped → GNT=0100, {S0,S1}=10 for 3 cycles. Then GNT=0000, ACTIVE=0, {S0,S1} stays 10.
- Hold limit with MAX_HOLD=8: REQ=1111 constant → GNT sequence 0001×8, 0010×8, 0100×8, 1000×8, then 0001. No gaps; {S0,S1} tracks 00,01,10,11.
- Pointer rotation: owner 1 releases while REQ=0011 → next grant goes to 0 (scan 2,3,0). Requester 1 is served only after 0 releases.
- Sole requester expiry: REQ=0010 held 20 cycles, MAX_HOLD=8 → GNT=0010 continuously, CNT restarting at 1 on cycles 9 and 17. ACTIVE never drops.
- Async reset mid-grant: RST_N pulsed low between edges while GNT=1000 → GNT=0000 and ACTIVE=0 before the next edge. After release with REQ=1000, grant resumes one cycle later.
